hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 6 +
 rtl/hazard_if.sv | 36 +++
 rtl/hazard_load_use_detect.sv | 16 +
 rtl/hazard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths and state encoding for the pipeline hazard logic
package hazard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int TIMER_W    = 10;
    typedef enum logic [1:0] {RUN, LD_STALL, MEM_WAIT} hz_state_e;
endpackage

// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-controller signal bundle
interface hazard_if;
    import hazard_pkg::*;
    logic [REG_ADDR_W-1:0] i_rs1_addr_ID;
    logic [REG_ADDR_W-1:0] i_rs2_addr_ID;
    logic                  i_rs1_used_ID;
    logic                  i_rs2_used_ID;
    logic [REG_ADDR_W-1:0] i_rd_addr_EX;
    logic                  i_load_EX;
    logic                  i_redirect_EX;
    logic                  i_lsu_req_MEM;
    logic                  i_lsu_ack_MEM;
    logic                  o_stall_IF;
    logic                  o_stall_ID;
    logic                  o_stall_EX;
    logic                  o_stall_MEM;
    logic                  o_stall_WB;
    logic                  o_flush_ID;
    logic                  o_flush_EX;
    logic                  o_flush_MEM;
    logic                  o_flush_WB;
    logic                  o_mem_timeout;
    logic [31:0]           o_stall_cycles;
    modport master (
        output i_rs1_addr_ID, i_rs2_addr_ID, i_rs1_used_ID, i_rs2_used_ID, i_rd_addr_EX,
               i_load_EX, i_redirect_EX, i_lsu_req_MEM, i_lsu_ack_MEM,
        input  o_stall_IF, o_stall_ID, o_stall_EX, o_stall_MEM, o_stall_WB,
               o_flush_ID, o_flush_EX, o_flush_MEM, o_flush_WB, o_mem_timeout, o_stall_cycles
    );
    modport slave (
        input  i_rs1_addr_ID, i_rs2_addr_ID, i_rs1_used_ID, i_rs2_used_ID, i_rd_addr_EX,
               i_load_EX, i_redirect_EX, i_lsu_req_MEM, i_lsu_ack_MEM,
        output o_stall_IF, o_stall_ID, o_stall_EX, o_stall_MEM, o_stall_WB,
               o_flush_ID, o_flush_EX, o_flush_MEM, o_flush_WB, o_mem_timeout, o_stall_cycles
    );
endinterface

// File: rtl/hazard_load_use_detect.sv
// load_use_detect: combinational load-use comparator, shared with the forwarding unit
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic                  i_rs1_used,
    input  logic                  i_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_load,
    output logic                  o_hit
);
    assign o_hit = i_load & (|i_rd_addr) &
                   ((i_rs1_used & (i_rs1_addr == i_rd_addr)) |
                    (i_rs2_used & (i_rs2_addr == i_rd_addr)));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for load-use, EX redirect and LSU waits
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LD_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic     i_clk,
    input  logic     i_rst,
    hazard_if.slave  hz
);
    localparam logic [1:0]         S_RUN   = RUN;
    localparam logic [1:0]         S_LD    = LD_STALL;
    localparam logic [1:0]         S_MW    = MEM_WAIT;
    localparam logic [1:0]         LD_INIT = 2'(LD_BUBBLES - 2);
    localparam logic [TIMER_W-1:0] TMO     = TIMER_W'(MEM_TIMEOUT);

    logic [1:0]         r_state;
    logic [1:0]         r_ret_state;
    logic [1:0]         r_ld_cnt;
    logic [TIMER_W-1:0] r_mem_timer;
    logic [31:0]        r_stall_cycles;

    logic w_hit, w_busy, w_in_mw, w_timeout, w_mem_stall, w_ld_req, w_ld_act, w_redir, w_stall_if;

    load_use_detect u_lud (
        .i_rs1_addr (hz.i_rs1_addr_ID),
        .i_rs2_addr (hz.i_rs2_addr_ID),
        .i_rs1_used (hz.i_rs1_used_ID),
        .i_rs2_used (hz.i_rs2_used_ID),
        .i_rd_addr  (hz.i_rd_addr_EX),
        .i_load     (hz.i_load_EX),
        .o_hit      (w_hit)
    );

    assign w_busy      = hz.i_lsu_req_MEM & ~hz.i_lsu_ack_MEM;
    assign w_in_mw     = r_state == S_MW;
    assign w_timeout   = w_in_mw & ~hz.i_lsu_ack_MEM & (r_mem_timer == TMO);
    // Inside MEM_WAIT the request may already be dropped; only ack or timeout releases.
    assign w_mem_stall = w_in_mw ? (~hz.i_lsu_ack_MEM & ~w_timeout) : w_busy;
    assign w_ld_req    = (r_state == S_RUN & w_hit) | (r_state == S_LD);
    assign w_redir     = ~w_mem_stall & hz.i_redirect_EX;
    assign w_ld_act    = ~w_mem_stall & ~hz.i_redirect_EX & w_ld_req;
    assign w_stall_if  = ~i_rst & (w_mem_stall | w_ld_act);

    assign hz.o_stall_IF     = w_stall_if;
    assign hz.o_stall_ID     = w_stall_if;
    assign hz.o_stall_EX     = ~i_rst & w_mem_stall;
    assign hz.o_stall_MEM    = ~i_rst & w_mem_stall;
    assign hz.o_stall_WB     = 1'b0;
    assign hz.o_flush_ID     = i_rst | w_redir;
    assign hz.o_flush_EX     = i_rst | w_redir | w_ld_act;
    assign hz.o_flush_MEM    = i_rst;
    assign hz.o_flush_WB     = i_rst | w_mem_stall;
    assign hz.o_mem_timeout  = ~i_rst & w_timeout;
    assign hz.o_stall_cycles = r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_RUN;
            r_ret_state    <= S_RUN;
            r_ld_cnt       <= '0;
            r_mem_timer    <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_stall_cycles <= r_stall_cycles + 32'(w_stall_if);
            if (w_in_mw) begin
                if (hz.i_lsu_ack_MEM | w_timeout) r_state <= r_ret_state;
                else r_mem_timer <= r_mem_timer + TIMER_W'(1);
            end else if (w_busy) begin
                r_state     <= S_MW;
                r_ret_state <= r_state;
                r_mem_timer <= TIMER_W'(1);
            end else if (hz.i_redirect_EX) begin
                r_state <= S_RUN;
            end else if (r_state == S_LD) begin
                if (r_ld_cnt == 2'd0) r_state <= S_RUN;
                else r_ld_cnt <= r_ld_cnt - 2'd1;
            end else if (w_hit && LD_BUBBLES > 1) begin
                r_state  <= S_LD;
                r_ld_cnt <= LD_INIT;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench running two parameterisations against a cycle model
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       u1 = 1'b0, u2 = 1'b0, ld = 1'b0, redir = 1'b0, req = 1'b0, ack = 1'b0;

    logic [9:0]  act_ctl[2];
    logic [31:0] act_cyc[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hazard_if hzi ();
        assign hzi.i_rs1_addr_ID = rs1;
        assign hzi.i_rs2_addr_ID = rs2;
        assign hzi.i_rs1_used_ID = u1;
        assign hzi.i_rs2_used_ID = u2;
        assign hzi.i_rd_addr_EX  = rd;
        assign hzi.i_load_EX     = ld;
        assign hzi.i_redirect_EX = redir;
        assign hzi.i_lsu_req_MEM = req;
        assign hzi.i_lsu_ack_MEM = ack;
        assign act_ctl[g] = {hzi.o_stall_IF, hzi.o_stall_ID, hzi.o_stall_EX, hzi.o_stall_MEM,
                             hzi.o_stall_WB, hzi.o_flush_ID, hzi.o_flush_EX, hzi.o_flush_MEM,
                             hzi.o_flush_WB, hzi.o_mem_timeout};
        assign act_cyc[g] = hzi.o_stall_cycles;
        hazard_ctrl #(.LD_BUBBLES(g == 0 ? 2 : 3), .MEM_TIMEOUT(g == 0 ? 3 : 8)) dut (
            .i_clk (clk),
            .i_rst (rst),
            .hz    (hzi)
        );
    end

    // Model: remaining bubble cycles, LSU wait flag and elapsed wait cycles per instance.
    int          nb[2] = '{2, 3};
    int          to[2] = '{3, 8};
    int          in_wait[2] = '{0, 0};
    int          waited[2] = '{0, 0};
    int          bub[2] = '{0, 0};
    logic [31:0] cnt[2] = '{32'd0, 32'd0};

    typedef struct packed {
        logic [1:0][9:0]  ctl;
        logic [1:0][31:0] cyc;
        int               n;
    } exp_t;
    exp_t q[$];

    int checks = 0, failures = 0, cycle_n = 0;

    function automatic logic hit_f();
        return ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    function automatic logic [9:0] out_f(int k);
        logic ms, lds;
        logic [9:0] o;
        if (rst) return 10'b0000011110;
        ms  = in_wait[k] != 0 ? (!ack && waited[k] < to[k]) : (req && !ack);
        lds = in_wait[k] == 0 && (bub[k] > 0 || hit_f());
        o = ms ? 10'b1111000010 : redir ? 10'b0000011000 : lds ? 10'b1100001000 : 10'b0;
        o[0] = in_wait[k] != 0 && !ack && waited[k] == to[k];
        return o;
    endfunction

    task automatic step(int k, logic [9:0] o);
        if (rst) begin
            in_wait[k] = 0; waited[k] = 0; bub[k] = 0; cnt[k] = '0;
        end else begin
            cnt[k] = cnt[k] + 32'(o[9]);
            if (in_wait[k] != 0) begin
                if (ack || waited[k] == to[k]) in_wait[k] = 0;
                else waited[k]++;
            end else if (req && !ack) begin
                in_wait[k] = 1; waited[k] = 1;
            end else if (redir) bub[k] = 0;
            else if (bub[k] > 0) bub[k]--;
            else if (hit_f()) bub[k] = nb[k] - 1;
        end
    endtask

    task automatic cyc();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.ctl[k] = out_f(k);
            e.cyc[k] = cnt[k];
        end
        e.n = cycle_n;
        q.push_back(e);
        for (int k = 0; k < 2; k++) step(k, e.ctl[k]);
        cycle_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int n, logic r_, logic l_, logic [4:0] d_, logic [4:0] a_, logic v_,
                       logic rdr_, logic rq_, logic ak_);
        rst = r_; ld = l_; rd = d_; rs1 = a_; u1 = v_; rs2 = '0; u2 = 1'b0;
        redir = rdr_; req = rq_; ack = ak_;
        repeat (n) cyc();
    endtask

    task automatic chk(string nm, int n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, n, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctl_b2_t3", e.n, 32'(act_ctl[0]), 32'(e.ctl[0]));
                chk("ctl_b3_t8", e.n, 32'(act_ctl[1]), 32'(e.ctl[1]));
                chk("cyc_b2_t3", e.n, act_cyc[0], e.cyc[0]);
                chk("cyc_b3_t8", e.n, act_cyc[1], e.cyc[1]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        drv(2, 1, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 5, 5, 1, 0, 0, 0);
        drv(4, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 1, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(4, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1);
        drv(2, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(4, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(8, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 7, 7, 1, 1, 0, 0);
        drv(1, 0, 1, 7, 7, 1, 0, 0, 0);
        drv(2, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1);
        drv(4, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 1, 9, 9, 1, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(3, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(3, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(2, 1, 0, 0, 0, 0, 0, 1, 0);
        drv(3, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            rst   = $urandom_range(0, 63) == 0;
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            u1    = 1'($urandom_range(0, 1));
            u2    = 1'($urandom_range(0, 1));
            ld    = 1'($urandom_range(0, 1));
            redir = $urandom_range(0, 7) == 0;
            req   = $urandom_range(0, 3) == 0;
            ack   = 1'($urandom_range(0, 1));
            cyc();
        end
        drv(2, 0, 0, 0, 0, 0, 0, 0, 0);
        #10;
        chk("scoreboard_drained", cycle_n, 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
